key_expand_iter: RTL
====================

KEY_EXPAND_ITER -- requirements
Module: key_expand_iter

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request to expand the cipher key on key_in.
REQ-004 SHALL have port key_in, input, 128 bits: AES-128 cipher key; bits 127:96 are w0, byte 0 at bits 127:120.
REQ-005 SHALL have port key_ready, input, 1 bit: the downstream round stage accepts the current round key.
REQ-006 SHALL have port round_key, output, 128 bits: current round key, same word and byte ordering as key_in.
REQ-007 SHALL have port round_idx, output, 4 bits: round number of round_key, 0..10.
REQ-008 SHALL have port key_valid, output, 1 bit: round_key and round_idx are valid.
REQ-009 SHALL have port busy, output, 1 bit: an expansion is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after round key 10 is accepted.

Function
REQ-011 SHALL implement the FSM states IDLE, EXPAND and FINISH, encoded in a registered state variable.
REQ-012 In IDLE, start=1 SHALL latch key_in into round_key and set round_idx=0, key_valid=1 and busy=1, and move the FSM to EXPAND on that edge.
REQ-013 In EXPAND, a transfer SHALL occur on a rising edge only when key_valid=1 and key_ready=1.
REQ-014 On a transfer with round_idx<10, the block SHALL load the next round key computed per FIPS-197, increment round_idx, and keep key_valid=1.
  - Next-key computation: w0'=w0^SubWord(RotWord(w3))^{Rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-015 Rcon SHALL be held in an 8-bit register: set to 8'h01 at load, and updated by xtime on each transfer.
  - xtime: shift left by one; XOR 8'h1B if bit 7 was set.
  - Sequence: 01,02,04,08,10,20,40,80,1B,36.
REQ-016 SubWord SHALL apply the FIPS-197 forward S-box to each of the four bytes combinationally, within the same cycle.
REQ-017 On a transfer with round_idx=10, the block SHALL clear key_valid and move to FINISH.
REQ-018 In FINISH, done SHALL be 1 for exactly that cycle, and on the next edge the block SHALL clear busy and return to IDLE.
REQ-019 While key_valid=1 and key_ready=0, the block SHALL hold round_key, round_idx and Rcon stable for any number of cycles.
REQ-020 start asserted while in EXPAND or FINISH SHALL be ignored, with no effect on any state or output.
REQ-021 start held high through FINISH into IDLE SHALL begin a new expansion on the first IDLE edge.
REQ-022 Latency SHALL be 1 cycle from start to round 0 valid; with key_ready held at 1, round 10 is valid 11 cycles after start and done is asserted 12 cycles after start.
REQ-023 round_idx SHALL never exceed 10 and SHALL never wrap.

Reset
REQ-024 RST=1 SHALL immediately, without waiting for a clock edge, force the following values:
  - state=IDLE, round_key=0, round_idx=0, Rcon=8'h01;
  - key_valid=0, busy=0, done=0.
REQ-025 RST asserted mid-expansion SHALL abort the expansion, and after release no key_valid or done SHALL be produced until a new start.
REQ-026 start sampled on the first rising edge after RST deasserts SHALL be honoured normally.

Verification
REQ-027 Zero key: key_in=0, start pulse, key_ready=1 -> round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e, done exactly once.
REQ-028 FIPS-197 key: key_in=2b7e151628aed2a6abf7158809cf4f3c -> round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 Backpressure: key_ready=0 for 5 cycles at round_idx=3 -> round_key and round_idx unchanged throughout; the sequence resumes correctly and done arrives 5 cycles late.
REQ-030 Ignored start: start pulse with a different key at round_idx=6 -> remaining round keys still match the original key; no restart occurs.
REQ-031 Reset mid-run: RST pulsed at round_idx=4 -> all outputs 0 immediately; after release and a new start, round 0 equals the new key_in.

Source files
------------

// File: rtl/key_expand_iter.sv
// Iterative AES-128 key expansion: produces round keys 0..10, one per accepted
// valid/ready handshake, deriving each key from the previous one and a running Rcon.
module key_expand_iter (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LastRound = 4'd10;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SboxFlat = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StExpand, StFinish} state_e;

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     rcon_q, rcon_d;

  logic           launch;
  logic           xfer;
  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    rot_w3, sub_w3;
  logic [31:0]    n0, n1, n2, n3;
  logic [7:0]     rcon_next;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxFlat[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign launch = (state_q == StIdle) && start;
  assign xfer   = (state_q == StExpand) && key_ready;

  // Next round key, purely combinational from the current key and Rcon.
  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3    = {w3[23:0], w3[31:24]};
  assign sub_w3    = sub_word(rot_w3);
  assign n0        = w0 ^ sub_w3 ^ {rcon_q, 24'h000000};
  assign n1        = w1 ^ n0;
  assign n2        = w2 ^ n1;
  assign n3        = w3 ^ n2;
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // State register and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StExpand;
      StExpand: if (xfer && (idx_q == LastRound)) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next values; everything holds unless a load or a transfer occurs.
  always_comb begin
    key_d  = key_q;
    idx_d  = idx_q;
    rcon_d = rcon_q;
    if (launch) begin
      key_d  = key_in;
      idx_d  = '0;
      rcon_d = 8'h01;
    end else if (xfer && (idx_q != LastRound)) begin
      key_d  = {n0, n1, n2, n3};
      idx_d  = idx_q + 4'd1;
      rcon_d = rcon_next;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    round_key = key_q;
    round_idx = idx_q;
    key_valid = (state_q == StExpand);
    busy      = (state_q != StIdle);
    done      = (state_q == StFinish);
  end

endmodule
